// File: rtl/systolic_mesh_v2.sv
// systolic_mesh_v2: output-stationary ROWS x COLS systolic matrix-multiply engine.
// A and B arrive unskewed, one k-slice per beat. They are skewed internally,
// accumulated in place as C = A*B over a run-time K, and then drained one
// result column per ready/valid beat.
module systolic_mesh_v2 #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 16,
  localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic [K_WIDTH-1:0]            k_len_i,
  input  logic                          signed_i,
  input  logic [ROWS*DATA_WIDTH-1:0]    a_i,
  input  logic [COLS*DATA_WIDTH-1:0]    b_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [ROWS*ACC_WIDTH-1:0]     res_data_o,
  output logic [COL_W-1:0]              res_col_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int DW   = DATA_WIDTH;
  localparam int AW   = ACC_WIDTH;
  localparam int FL_W = $clog2(ROWS + COLS);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(ROWS + COLS - 2);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
    $error("systolic_mesh_v2: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Extend both operands to the accumulator width (sign- or zero-) and
  // multiply there; the low AW bits equal the extended full-width product.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic          sgn);
    logic [AW-1:0] ea;
    logic [AW-1:0] eb;
    ea = {{(AW-DW){sgn & a[DW-1]}}, a};
    eb = {{(AW-DW){sgn & b[DW-1]}}, b};
    return ea * eb;
  endfunction

  state_t                 state_q;
  logic [K_WIDTH-1:0]     k_rem_q;
  logic                   signed_q;
  logic                   in_ready_q;
  logic [FL_W-1:0]        flush_q;
  logic                   res_valid_q;
  logic [COL_W-1:0]       res_col_q;
  logic [ROWS*AW-1:0]     res_data_q;
  logic                   done_q;

  logic                   accept_s;
  logic                   clear_s;
  logic [ROWS*DW-1:0]     a_edge_s;
  logic [ROWS-1:0]        a_edge_v_s;
  logic [COLS*DW-1:0]     b_edge_s;
  logic [COLS-1:0]        b_edge_v_s;
  logic [ROWS*COLS*DW-1:0] a_op_s;
  logic [ROWS*COLS-1:0]   a_tag_s;
  logic [ROWS*COLS*DW-1:0] b_op_s;
  logic [ROWS*COLS-1:0]   b_tag_s;
  logic [ROWS*COLS*AW-1:0] acc_s;
  logic [ROWS*AW-1:0]     col_data_s;
  int                     sel_s;

  assign accept_s = in_valid_i & in_ready_q;
  assign clear_s  = (state_q == S_IDLE) & start_i;

  // West-edge skew: lane r of A is delayed r cycles before column 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_pass
      assign a_edge_s[DW-1:0] = a_i[DW-1:0];
      assign a_edge_v_s[0]    = accept_s;
    end else begin : g_dly
      logic [DW-1:0] dat_q [r];
      logic [r-1:0]  vld_q;
      // Delay line for A lane r, carrying the beat-valid tag alongside
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          for (int i = 0; i < r; i++) dat_q[i] <= '0;
          vld_q <= '0;
        end else begin
          dat_q[0] <= a_i[r*DW +: DW];
          vld_q[0] <= accept_s;
          for (int i = 1; i < r; i++) begin
            dat_q[i] <= dat_q[i-1];
            vld_q[i] <= vld_q[i-1];
          end
        end
      end
      assign a_edge_s[r*DW +: DW] = dat_q[r-1];
      assign a_edge_v_s[r]        = vld_q[r-1];
    end
  end

  // North-edge skew: lane c of B is delayed c cycles before row 0.
  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_pass
      assign b_edge_s[DW-1:0] = b_i[DW-1:0];
      assign b_edge_v_s[0]    = accept_s;
    end else begin : g_dly
      logic [DW-1:0] dat_q [c];
      logic [c-1:0]  vld_q;
      // Delay line for B lane c, carrying the beat-valid tag alongside
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          for (int i = 0; i < c; i++) dat_q[i] <= '0;
          vld_q <= '0;
        end else begin
          dat_q[0] <= b_i[c*DW +: DW];
          vld_q[0] <= accept_s;
          for (int i = 1; i < c; i++) begin
            dat_q[i] <= dat_q[i-1];
            vld_q[i] <= vld_q[i-1];
          end
        end
      end
      assign b_edge_s[c*DW +: DW] = dat_q[c-1];
      assign b_edge_v_s[c]        = vld_q[c-1];
    end
  end

  // PE mesh: A hops east, B hops south, each PE owns one accumulator.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int IDX = r * COLS + c;
      logic [AW-1:0] acc_q;
      logic [AW-1:0] prod_s;

      if (c == 0) begin : g_a_west
        assign a_op_s[IDX*DW +: DW] = a_edge_s[r*DW +: DW];
        assign a_tag_s[IDX]         = a_edge_v_s[r];
      end else begin : g_a_hop
        logic [DW-1:0] a_q;
        logic          a_v_q;
        // Take the west neighbour's A operand and tag one cycle later
        always_ff @(posedge clk_i) begin
          if (!rstn_i) begin
            a_q   <= '0;
            a_v_q <= 1'b0;
          end else begin
            a_q   <= a_op_s[(IDX-1)*DW +: DW];
            a_v_q <= a_tag_s[IDX-1];
          end
        end
        assign a_op_s[IDX*DW +: DW] = a_q;
        assign a_tag_s[IDX]         = a_v_q;
      end

      if (r == 0) begin : g_b_north
        assign b_op_s[IDX*DW +: DW] = b_edge_s[c*DW +: DW];
        assign b_tag_s[IDX]         = b_edge_v_s[c];
      end else begin : g_b_hop
        logic [DW-1:0] b_q;
        logic          b_v_q;
        // Take the north neighbour's B operand and tag one cycle later
        always_ff @(posedge clk_i) begin
          if (!rstn_i) begin
            b_q   <= '0;
            b_v_q <= 1'b0;
          end else begin
            b_q   <= b_op_s[(IDX-COLS)*DW +: DW];
            b_v_q <= b_tag_s[IDX-COLS];
          end
        end
        assign b_op_s[IDX*DW +: DW] = b_q;
        assign b_tag_s[IDX]         = b_v_q;
      end

      assign prod_s = mul_ext(a_op_s[IDX*DW +: DW], b_op_s[IDX*DW +: DW], signed_q);

      // Accumulate only when both tags are set; a new run starts from zero
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          acc_q <= '0;
        end else if (clear_s) begin
          acc_q <= '0;
        end else if (a_tag_s[IDX] & b_tag_s[IDX]) begin
          acc_q <= acc_q + prod_s;
        end else begin
          acc_q <= acc_q;
        end
      end
      assign acc_s[IDX*AW +: AW] = acc_q;
    end
  end

  // Select the column the next drain beat will present
  always_comb begin
    sel_s      = 0;
    col_data_s = '0;
    if (state_q == S_DRAIN) begin
      sel_s = int'(res_col_q) + 1;
    end else begin
      sel_s = 0;
    end
    for (int r = 0; r < ROWS; r++) begin
      if (sel_s < COLS) begin
        col_data_s[r*AW +: AW] = acc_s[(r*COLS + sel_s)*AW +: AW];
      end else begin
        col_data_s[r*AW +: AW] = '0;
      end
    end
  end

  // Run control FSM with registered handshake, result and status outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      k_rem_q     <= '0;
      signed_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      flush_q     <= '0;
      res_valid_q <= 1'b0;
      res_col_q   <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            signed_q <= signed_i;
            k_rem_q  <= k_len_i;
            if (k_len_i != '0) begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= S_DRAIN;
              res_valid_q <= 1'b1;
              res_col_q   <= '0;
              res_data_q  <= '0;
            end
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            k_rem_q <= k_rem_q - K_WIDTH'(1);
            if (k_rem_q == K_WIDTH'(1)) begin
              in_ready_q <= 1'b0;
              flush_q    <= '0;
              state_q    <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            state_q     <= S_DRAIN;
            res_valid_q <= 1'b1;
            res_col_q   <= '0;
            res_data_q  <= col_data_s;
          end else begin
            flush_q <= flush_q + FL_W'(1);
          end
        end
        S_DRAIN: begin
          if (res_valid_q && res_ready_i) begin
            if (res_col_q == COL_LAST) begin
              res_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              res_col_q  <= res_col_q + COL_W'(1);
              res_data_q <= col_data_s;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_col_o   = res_col_q;
  assign res_data_o  = res_data_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
